lanectrl_pause_initiator: RTL



---
 rtl/lanectrl_pause_pkg.sv | 19 +
 rtl/lanectrl_pause_dcnt.sv | 27 ++
 rtl/lanectrl_pause_initiator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lanectrl_pause_pkg.sv
// Shared types for the lane-controller pause initiator: FSM states and UPDATE_TYPE codes.
package lanectrl_pause_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StStrobe,
        StPost,
        StGuard,
        StAck,
        StWaitRel
    } state_e;

    localparam logic [1:0] UPD_INC  = 2'b00;
    localparam logic [1:0] UPD_DEC  = 2'b01;
    localparam logic [1:0] UPD_SLIP = 2'b10;
    localparam logic [1:0] UPD_LOAD = 2'b11;

endpackage

// File: rtl/lanectrl_pause_dcnt.sv
// Loadable down-counter with enable; holds at zero and flags it.
module lanectrl_pause_dcnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lanectrl_pause_initiator.sv
// Brackets each bit-align update with HS_IO_CLK_PAUSE, a single strobe and guard cycles.
// Optional OP_COUNT counter enabled by LANECTRL_PAUSE_INIT_OPCNT_EN.
module lanectrl_pause_initiator
    import lanectrl_pause_pkg::*;
#(
    parameter int unsigned PAUSE_PRE_CYCLES  = 2,
    parameter int unsigned PAUSE_POST_CYCLES = 2,
    parameter int unsigned GUARD_CYCLES      = 4,
    parameter int unsigned CNT_W             = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ,
    input  logic [1:0] UPDATE_TYPE,
    output logic       ACK,
    output logic       BUSY,
    output logic       HS_IO_CLK_PAUSE,
    output logic       DELAY_MOVE,
    output logic       DELAY_DIR,
    output logic       BIT_SLIP,
    output logic       DELAY_LOAD,
    output logic       ERR_REQ_DROP,
    output logic [7:0] OP_COUNT
);

    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PAUSE_PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(PAUSE_POST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic             err_q, err_d;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             strobe_d;

    lanectrl_pause_dcnt #(
        .CNT_W(CNT_W)
    ) u_dcnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .load    (cnt_load),
        .load_val(cnt_val),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_val  = PRE_LD;
        cnt_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    state_d  = StPre;
                    type_d   = UPDATE_TYPE;
                    err_d    = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = PRE_LD;
                end
            end
            StPre: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_d = StStrobe;
            end
            StStrobe: begin
                state_d  = StPost;
                cnt_load = 1'b1;
                cnt_val  = POST_LD;
            end
            StPost: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d  = StGuard;
                        cnt_load = 1'b1;
                        cnt_val  = GUARD_LD;
                    end
                end
            end
            StGuard: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_d = StAck;
            end
            StAck:     state_d = StWaitRel;
            StWaitRel: if (!REQ) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // The sequence never aborts on a dropped request; it only records the protocol error.
        if ((state_q inside {StPre, StStrobe, StPost, StGuard}) && !REQ) err_d = 1'b1;
    end

    assign strobe_d = (state_d == StStrobe);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= StIdle;
            type_q          <= UPD_INC;
            err_q           <= 1'b0;
            ACK             <= 1'b0;
            BUSY            <= 1'b0;
            HS_IO_CLK_PAUSE <= 1'b0;
            DELAY_MOVE      <= 1'b0;
            DELAY_DIR       <= 1'b0;
            BIT_SLIP        <= 1'b0;
            DELAY_LOAD      <= 1'b0;
        end else begin
            state_q         <= state_d;
            type_q          <= type_d;
            err_q           <= err_d;
            ACK             <= (state_d == StAck);
            BUSY            <= (state_d != StIdle);
            HS_IO_CLK_PAUSE <= (state_d inside {StPre, StStrobe, StPost});
            DELAY_MOVE      <= strobe_d && ((type_d == UPD_INC) || (type_d == UPD_DEC));
            DELAY_DIR       <= strobe_d && (type_d == UPD_INC);
            BIT_SLIP        <= strobe_d && (type_d == UPD_SLIP);
            DELAY_LOAD      <= strobe_d && (type_d == UPD_LOAD);
        end
    end

    assign ERR_REQ_DROP = err_q;

`ifdef LANECTRL_PAUSE_INIT_OPCNT_EN
    logic [7:0] op_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_cnt_q <= 8'd0;
        end else if ((state_d == StAck) && (op_cnt_q != 8'hFF)) begin
            op_cnt_q <= op_cnt_q + 8'd1;
        end
    end

    assign OP_COUNT = op_cnt_q;
`else
    assign OP_COUNT = 8'd0;
`endif

endmodule
